fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register and drives its if-side inputs.
- Owns the PC, issues instruction-memory read requests, and tracks redirects from branch/jump resolution, including redirects that arrive while a fetch is still outstanding.
- Produces a fetched instruction plus PC+4 (JAL link address), or a bubble.
- Stops fetching once a HALT opcode has been fetched.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'h3F, opcode (instr[31:26]) that halts fetch.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- imemREN  output  1  instruction memory read enable
- imemaddr  output  32  instruction memory address (= PC)
- imemload  input  32  instruction read data, valid when ihit=1
- ihit  input  1  instruction memory hit for the current imemaddr
- stall  input  1  hazard unit: hold IF/ID contents and PC
- redirect  input  1  branch/jump taken; load redirect_addr
- redirect_addr  input  32  target PC
- ifinstr  output  32  instruction to IF/ID
- ifJALjump_addr  output  32  PC+4 of the fetched instruction
- ifW  output  1  IF/ID write enable
- ifRST  output  1  IF/ID load-bubble (zero) request
- fetch_pc  output  32  current PC, debug/observability

Behaviour:
- Reset state (asynchronous, while nRST=0):
  - pc=PC_INIT, state=RUN.
  - Outputs: imemREN=0, imemaddr=PC_INIT, ifW=1, ifRST=1, ifinstr=0, ifJALjump_addr=0.
- Outputs are combinational from pc, state and inputs:
  - imemaddr = pc at all times.
  - imemREN = 1 in RUN and REDIR_WAIT; 0 in HALTED and during reset.
  - ifJALjump_addr = pc + 32'd4, computed mod 2^32 (0xFFFFFFFC wraps to 0).
  - ifinstr = imemload when a valid fetch is accepted; 0 otherwise.
- States: RUN, REDIR_WAIT, HALTED.
- Priority in all states: redirect > stall > ihit.
- RUN:
  - redirect=1: pc <= redirect_addr; ifW=1, ifRST=1. If ihit=0 that cycle, go to REDIR_WAIT; otherwise stay in RUN.
  - stall=1 (no redirect): ifW=0; pc holds; ihit is ignored and the fetch is re-presented next cycle.
  - ihit=1: accept the fetch. ifW=1, ifRST=0, pc <= pc+4.
    - If imemload[31:26]==HALT_OP: pc holds instead of advancing, and state goes to HALTED. The HALT instruction itself is still passed to IF/ID.
  - ihit=0: ifW=1, ifRST=1 (bubble); pc holds.
- REDIR_WAIT (drops the stale response left over from the pre-redirect request):
  - First ihit=1 is discarded: ifW=1, ifRST=1, go to RUN, pc holds.
  - ihit=0: bubble, stay in REDIR_WAIT.
  - redirect=1: pc <= redirect_addr, stay in REDIR_WAIT.
  - stall=1: ifW=0. The discard still occurs if ihit=1 that cycle.
- HALTED:
  - Not stalled: ifW=1, ifRST=1 every cycle (drains bubbles). Stalled: ifW=0.
  - redirect=1 (HALT was on a wrong path): pc <= redirect_addr, go to RUN, bubble that cycle.
- Latency: an instruction reaches IF/ID at the clock edge of the cycle in which ihit=1, with no extra register in this block.
- Reset asserted mid-operation: immediate return to reset state; any outstanding request is abandoned.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall_cyc[31:0], both reset to 0.
  - perf_fetched increments per accepted fetch (RUN, ihit=1, no stall, no redirect).
  - perf_stall_cyc increments per cycle with imemREN=1 and (ihit=0 or stall=1).
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ihit=1 constantly with imemload=32'h2008_0005, 32'h2009_0003 -> imemaddr 0x0, 0x4, 0x8 on consecutive cycles; ifJALjump_addr 0x4, 0x8; ifW=1, ifRST=0.
- ihit=0 for 3 cycles at pc=0x10, then ihit=1 -> 3 bubbles (ifRST=1), pc stays 0x10, then the instruction is accepted and pc=0x14.
- stall=1 for 2 cycles with ihit=1 at pc=0x20 -> ifW=0 and pc=0x20 both cycles; the first cycle after stall drops accepts the instruction and pc=0x24.
- redirect=1, redirect_addr=0x100 while ihit=0 at pc=0x40:
  - state goes to REDIR_WAIT and the next ihit is discarded with a bubble;
  - the next ihit at 0x100 is accepted and ifJALjump_addr=0x104.
- Fetch imemload=32'hFC00_0000 at pc=0x80 -> HALT written to IF/ID, imemREN=0, pc=0x80, bubbles thereafter. A later redirect to 0x200 -> RUN, imemaddr=0x200.
- nRST pulsed low mid-stall at pc=0x300 -> pc=PC_INIT, ifRST=1, imemREN=0 immediately. With FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's instruction-memory, hazard/redirect and IF/ID
// signals. With FETCH_PERF_EN defined, the performance counter outputs are
// carried here as well.
interface fetch_unit_if;
   // instruction memory side
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        ihit;
   // hazard / branch resolution side
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_addr;
   // IF/ID register side
   logic [31:0] ifinstr;
   logic [31:0] ifJALjump_addr;
   logic        ifW;
   logic        ifRST;
   logic [31:0] fetch_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cyc;

   modport master (
      output imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST, fetch_pc,
             perf_fetched, perf_stall_cyc,
      input  imemload, ihit, stall, redirect, redirect_addr
   );
   modport slave (
      input  imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST, fetch_pc,
             perf_fetched, perf_stall_cyc,
      output imemload, ihit, stall, redirect, redirect_addr
   );
`else
   modport master (
      output imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST, fetch_pc,
      input  imemload, ihit, stall, redirect, redirect_addr
   );
   modport slave (
      input  imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST, fetch_pc,
      output imemload, ihit, stall, redirect, redirect_addr
   );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, requests
// instructions, drops the stale response after a redirect that lands while a
// fetch is outstanding, and stops fetching after a HALT opcode.
// Optional macro FETCH_PERF_EN adds saturating fetch / stall-cycle counters.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic         CLK,
   input  logic         nRST,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {RUN, REDIR_WAIT, HALTED} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        accept;

   // State and PC registers; reset abandons any outstanding request
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         pc_q    <= PC_INIT;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state/PC and IF/ID controls; priority is redirect > stall > ihit
   always_comb begin
      state_d            = state_q;
      pc_d               = pc_q;
      accept             = 1'b0;
      bus.ifW            = 1'b1;
      bus.ifRST          = 1'b1;
      bus.ifinstr        = 32'h0;
      bus.imemaddr       = pc_q;
      bus.imemREN        = nRST && (state_q != HALTED);
      bus.ifJALjump_addr = nRST ? (pc_q + 32'd4) : 32'h0;
      bus.fetch_pc       = pc_q;
      case (state_q)
         RUN: begin
            if (bus.redirect) begin
               pc_d = bus.redirect_addr;
               // the request for the old PC is still in flight if no hit now
               if (!bus.ihit) state_d = REDIR_WAIT;
            end else if (bus.stall) begin
               bus.ifW   = 1'b0;
               bus.ifRST = 1'b0;
            end else if (bus.ihit) begin
               accept      = 1'b1;
               bus.ifRST   = 1'b0;
               bus.ifinstr = bus.imemload;
               if (bus.imemload[31:26] == HALT_OP) state_d = HALTED;
               else                                pc_d    = pc_q + 32'd4;
            end
         end
         REDIR_WAIT: begin
            if (bus.redirect) begin
               pc_d = bus.redirect_addr;
            end else begin
               if (bus.stall) begin
                  bus.ifW   = 1'b0;
                  bus.ifRST = 1'b0;
               end
               // the first hit belongs to the pre-redirect request
               if (bus.ihit) state_d = RUN;
            end
         end
         HALTED: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_addr;
               state_d = RUN;
            end else if (bus.stall) begin
               bus.ifW   = 1'b0;
               bus.ifRST = 1'b0;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
      if (!nRST) begin
         bus.ifW     = 1'b1;
         bus.ifRST   = 1'b1;
         bus.ifinstr = 32'h0;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
      return v;
   endfunction

   // Counter updates: accepted fetches and cycles spent waiting or stalled
   always_comb begin
      perf_fetched_d   = sat_inc(perf_fetched_q, accept);
      perf_stall_cyc_d = sat_inc(perf_stall_cyc_q,
                                 bus.imemREN && (!bus.ihit || bus.stall));
   end

   // Counter registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf_fetched_q   <= 32'h0;
         perf_stall_cyc_q <= 32'h0;
      end else begin
         perf_fetched_q   <= perf_fetched_d;
         perf_stall_cyc_q <= perf_stall_cyc_d;
      end
   end

   assign bus.perf_fetched   = perf_fetched_q;
   assign bus.perf_stall_cyc = perf_stall_cyc_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;
   logic CLK;
   logic nRST;
   fetch_unit_if bus ();

   fetch_unit #(.PC_INIT(32'h0000_0000), .HALT_OP(6'h3F)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.master)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // model: PC, "halted", and "a stale response must be dropped"
   logic [31:0] m_pc;
   bit          m_halted;
   bit          m_drop;
   longint      m_fetched;
   longint      m_stallc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_halted = 0; m_drop = 0; m_fetched = 0; m_stallc = 0;
   endtask

   task automatic chk_perf();
`ifdef FETCH_PERF_EN
      chk("perf_fetched", bus.perf_fetched,
          (m_fetched > 64'hFFFFFFFF) ? 32'hFFFF_FFFF : m_fetched[31:0]);
      chk("perf_stall_cyc", bus.perf_stall_cyc,
          (m_stallc > 64'hFFFFFFFF) ? 32'hFFFF_FFFF : m_stallc[31:0]);
`endif
   endtask

   // One clock cycle with the inputs currently applied: check the
   // combinational outputs, clock, then advance the model and check the PC.
   task automatic cycle();
      logic [31:0] e_instr, n_pc;
      bit e_w, e_rst, e_ren, n_halt, n_drop, acc;
      #1;
      e_ren = !m_halted; e_w = 1; e_rst = 1; e_instr = 0; acc = 0;
      n_pc = m_pc; n_halt = m_halted; n_drop = m_drop;
      if (bus.redirect) begin
         n_pc   = bus.redirect_addr;
         n_halt = 0;
         n_drop = m_halted ? 0 : (m_drop || !bus.ihit);
      end else if (bus.stall) begin
         e_w = 0;
         if (!m_halted && m_drop && bus.ihit) n_drop = 0;
      end else if (m_halted) begin
         e_rst = 1;
      end else if (m_drop) begin
         if (bus.ihit) n_drop = 0;
      end else if (bus.ihit) begin
         acc = 1; e_rst = 0; e_instr = bus.imemload;
         if (bus.imemload[31:26] == 6'h3F) n_halt = 1;
         else n_pc = m_pc + 32'd4;
      end
      chk("imemaddr", bus.imemaddr, m_pc);
      chk("imemREN", {31'b0, bus.imemREN}, {31'b0, e_ren});
      chk("ifW", {31'b0, bus.ifW}, {31'b0, e_w});
      if (e_w) chk("ifRST", {31'b0, bus.ifRST}, {31'b0, e_rst});
      chk("ifinstr", bus.ifinstr, e_instr);
      chk("ifJALjump_addr", bus.ifJALjump_addr, m_pc + 32'd4);
      if (acc) m_fetched++;
      if (e_ren && (!bus.ihit || bus.stall)) m_stallc++;
      @(posedge CLK);
      #1;
      m_pc = n_pc; m_halted = n_halt; m_drop = n_drop;
      chk("fetch_pc", bus.fetch_pc, m_pc);
      chk_perf();
   endtask

   task automatic drive(input bit hit, input bit stl, input bit rd,
                        input logic [31:0] raddr, input logic [31:0] load);
      bus.ihit = hit; bus.stall = stl; bus.redirect = rd;
      bus.redirect_addr = raddr; bus.imemload = load;
   endtask

   initial begin
      logic [31:0] ra;
      model_reset();
      nRST = 1'b0;
      drive(0, 0, 0, 32'h0, 32'h0);
      #3;
      // reset state
      chk("rst_imemREN", {31'b0, bus.imemREN}, 32'h0);
      chk("rst_imemaddr", bus.imemaddr, 32'h0);
      chk("rst_ifW", {31'b0, bus.ifW}, 32'h1);
      chk("rst_ifRST", {31'b0, bus.ifRST}, 32'h1);
      chk("rst_ifinstr", bus.ifinstr, 32'h0);
      chk("rst_jal", bus.ifJALjump_addr, 32'h0);
      chk_perf();
      @(posedge CLK); #1;
      nRST = 1'b1;

      // sequential fetch
      drive(1, 0, 0, 0, 32'h2008_0005); cycle();
      drive(1, 0, 0, 0, 32'h2009_0003); cycle();
      chk("seq_pc", bus.fetch_pc, 32'h8);

      // misses at 0x10
      drive(1, 0, 1, 32'h10, 32'h0); cycle();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 32'h1234_5678); cycle(); end
      chk("miss_pc_held", bus.fetch_pc, 32'h10);
      drive(1, 0, 0, 0, 32'h0000_0020); cycle();
      chk("miss_pc_adv", bus.fetch_pc, 32'h14);

      // stall at 0x20
      drive(1, 0, 1, 32'h20, 32'h0); cycle();
      for (int i = 0; i < 2; i++) begin drive(1, 1, 0, 0, 32'h0110_0020); cycle(); end
      chk("stall_pc_held", bus.fetch_pc, 32'h20);
      drive(1, 0, 0, 0, 32'h0110_0020); cycle();
      chk("stall_pc_adv", bus.fetch_pc, 32'h24);

      // redirect during a miss, stale response dropped
      drive(1, 0, 1, 32'h40, 32'h0); cycle();
      drive(0, 0, 1, 32'h100, 32'h0); cycle();
      drive(1, 0, 0, 0, 32'hDEAD_BEEF); cycle();
      chk("drop_pc", bus.fetch_pc, 32'h100);
      drive(1, 0, 0, 0, 32'h2008_0001);
      #1;
      chk("redir_jal", bus.ifJALjump_addr, 32'h104);
      chk("redir_accept_rst", {31'b0, bus.ifRST}, 32'h0);
      cycle();

      // HALT at 0x80, drained bubbles, then redirect out
      drive(1, 0, 1, 32'h80, 32'h0); cycle();
      drive(1, 0, 0, 0, 32'hFC00_0000); cycle();
      chk("halt_pc", bus.fetch_pc, 32'h80);
      chk("halt_ren", {31'b0, bus.imemREN}, 32'h0);
      for (int i = 0; i < 2; i++) begin drive(1, 0, 0, 0, 32'h2008_0005); cycle(); end
      drive(0, 0, 1, 32'h200, 32'h0); cycle();
      chk("unhalt_addr", bus.imemaddr, 32'h200);
      chk("unhalt_ren", {31'b0, bus.imemREN}, 32'h1);

      // PC wrap
      drive(1, 0, 1, 32'hFFFF_FFFC, 32'h0); cycle();
      drive(1, 0, 0, 0, 32'h2008_0005);
      #1;
      chk("wrap_jal", bus.ifJALjump_addr, 32'h0);
      cycle();
      chk("wrap_pc", bus.fetch_pc, 32'h0);

      // reset mid-stall at 0x300
      drive(1, 0, 1, 32'h300, 32'h0); cycle();
      drive(1, 1, 0, 0, 32'h2008_0005); cycle();
      nRST = 1'b0;
      #1;
      chk("arst_pc", bus.fetch_pc, 32'h0);
      chk("arst_ifRST", {31'b0, bus.ifRST}, 32'h1);
      chk("arst_ren", {31'b0, bus.imemREN}, 32'h0);
      model_reset();
      chk_perf();
      #1;
      nRST = 1'b1;
      drive(1, 0, 0, 0, 32'h2008_0005); cycle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         ra = {$urandom_range(0, 32'h3FF), 2'b00};
         if ($urandom_range(0, 15) == 0) ra = 32'hFFFF_FFFC;
         drive($urandom_range(0, 2) != 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 9) == 0,
               ra,
               ($urandom_range(0, 19) == 0) ? {6'h3F, 26'($urandom)} : 32'($urandom));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
